// File: rtl/uart_core_param_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_core_param_if
// Description : Host/pin signal bundle for the parametrised UART core.
//               The slave modport is the UART; the master modport is the
//               host plus the board driving the serial input.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_core_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] din_tx;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx;
  logic                 done_tx;
  logic                 rx;
  logic [DATA_BITS-1:0] dout_rx;
  logic                 done_rx;
  logic                 parity_err;
  logic                 frame_err;

  modport master (
    output din_tx, tx_valid, rx,
    input  tx_ready, tx, done_tx, dout_rx, done_rx, parity_err, frame_err
  );

  modport slave (
    input  din_tx, tx_valid, rx,
    output tx_ready, tx, done_tx, dout_rx, done_rx, parity_err, frame_err
  );
endinterface
`default_nettype wire

// File: rtl/uart_core_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_core_param
// Description : Parametrised full-duplex UART. Independent TX and RX FSMs,
//               each with its own bit-period divider. RX input is
//               double-flopped, sampled at bit centre, with start-glitch
//               rejection and parity / framing error reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_core_param #(
  parameter int CLK_FREQ  = 1000000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic          clk,
  input  logic          rst,
  uart_core_param_if.slave bus
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] STOP_LAST  = CW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST  = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOPB_LAST = IW'(STOP_BITS - 1);
  localparam logic          ODD        = (PARITY == 2);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_baud
      $error("uart_core_param: CLK_FREQ/BAUD must be at least 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_core_param: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_core_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_core_param: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Transmitter
  // --------------------------------------------------------------------------
  state_t               tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [IW-1:0]        tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_q, tx_d;
  logic                 tx_ready_q;
  logic                 done_tx_q, done_tx_d;

  // TX state register; tx_ready follows the next state so it is high
  // exactly while the FSM sits in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
      tx_ready_q <= 1'b1;
      done_tx_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
      tx_ready_q <= (tx_state_d == S_IDLE);
      done_tx_q  <= done_tx_d;
    end
  end

  // TX next state: the line level for the next cycle is decided here so
  // the serial output comes straight from a flop.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    done_tx_d  = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        tx_d     = 1'b1;
        if (bus.tx_valid) begin
          tx_state_d = S_START;
          tx_shift_d = bus.din_tx;
          tx_par_d   = (^bus.din_tx) ^ ODD;
          tx_idx_d   = '0;
          tx_d       = 1'b0;
        end
      end
      S_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = S_DATA;
          tx_d       = tx_shift_q[0];
        end
      end
      S_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_idx_q == DATA_LAST) begin
            if (PARITY != 0) begin
              tx_state_d = S_PARITY;
              tx_d       = tx_par_q;
            end else begin
              tx_state_d = S_STOP;
              tx_d       = 1'b1;
            end
          end else begin
            tx_idx_d   = tx_idx_q + 1'b1;
            tx_shift_d = tx_shift_q >> 1;
            tx_d       = tx_shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = S_STOP;
          tx_d       = 1'b1;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (tx_cnt_q == STOP_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = S_IDLE;
          done_tx_d  = 1'b1;
        end
      end
      default: begin
        tx_state_d = S_IDLE;
        tx_cnt_d   = '0;
        tx_d       = 1'b1;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Receiver
  // --------------------------------------------------------------------------
  logic                 rx_meta_q, rx_s_q;
  state_t               rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [IW-1:0]        rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 perr_pend_q, perr_pend_d;
  logic                 ferr_pend_q, ferr_pend_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 done_rx_q, done_rx_d;

  // Two-flop synchroniser for the asynchronous serial input; resets to the
  // idle line level so no false start is seen after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // RX state register and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q  <= S_IDLE;
      rx_cnt_q    <= '0;
      rx_idx_q    <= '0;
      rx_shift_q  <= '0;
      perr_pend_q <= 1'b0;
      ferr_pend_q <= 1'b0;
      dout_q      <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      done_rx_q   <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_idx_q    <= rx_idx_d;
      rx_shift_q  <= rx_shift_d;
      perr_pend_q <= perr_pend_d;
      ferr_pend_q <= ferr_pend_d;
      dout_q      <= dout_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      done_rx_q   <= done_rx_d;
    end
  end

  // RX next state: half a bit into START re-checks the line, then every
  // full bit period lands on a bit centre. rx_idx is reused to count stops.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q + 1'b1;
    rx_idx_d    = rx_idx_q;
    rx_shift_d  = rx_shift_q;
    perr_pend_d = perr_pend_q;
    ferr_pend_d = ferr_pend_q;
    dout_d      = dout_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    done_rx_d   = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_s_q) begin
          rx_state_d  = S_START;
          rx_idx_d    = '0;
          perr_pend_d = 1'b0;
          ferr_pend_d = 1'b0;
        end
      end
      S_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_idx_q == DATA_LAST) begin
            rx_idx_d   = '0;
            rx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            rx_idx_d = rx_idx_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d    = '0;
          perr_pend_d = rx_s_q ^ (^rx_shift_q) ^ ODD;
          rx_state_d  = S_STOP;
        end
      end
      S_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d    = '0;
          ferr_pend_d = ferr_pend_q | ~rx_s_q;
          if (rx_idx_q == STOPB_LAST) begin
            rx_state_d = S_IDLE;
            dout_d     = rx_shift_q;
            perr_d     = perr_pend_q;
            ferr_d     = ferr_pend_q | ~rx_s_q;
            done_rx_d  = 1'b1;
          end else begin
            rx_idx_d = rx_idx_q + 1'b1;
          end
        end
      end
      default: begin
        rx_state_d = S_IDLE;
        rx_cnt_d   = '0;
      end
    endcase
  end

  assign bus.tx         = tx_q;
  assign bus.tx_ready   = tx_ready_q;
  assign bus.done_tx    = done_tx_q;
  assign bus.dout_rx    = dout_q;
  assign bus.done_rx    = done_rx_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_core_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_core_param
// Description : Directed bench for uart_core_param. dut0 runs the default
//               8N1 / 104 clocks-per-bit setup; dut1 runs 7 data bits, odd
//               parity, 2 stop bits at 16 clocks per bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_core_param;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_core_param_if #(.DATA_BITS(8)) bus0 ();
  uart_core_param_if #(.DATA_BITS(7)) bus1 ();

  logic loop0, loop1, rx_drv0, rx_drv1;
  assign bus0.rx = loop0 ? bus0.tx : rx_drv0;
  assign bus1.rx = loop1 ? bus1.tx : rx_drv1;

  uart_core_param dut0 (.clk(clk), .rst(rst), .bus(bus0));

  uart_core_param #(
    .CLK_FREQ(1000000), .BAUD(62500), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int checks = 0;
  int errors = 0;

  logic [7:0] lb_tbl [0:9] = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01,
                               8'h80, 8'h3C, 8'hC3, 8'h7E, 8'h96};

  // Capture of completed receptions / transmissions.
  int         rx0_cnt = 0, rx1_cnt = 0, tx0_cnt = 0;
  logic [7:0] cap0_dout;
  logic       cap0_perr, cap0_ferr;
  logic [6:0] cap1_dout;
  logic       cap1_perr, cap1_ferr;

  always @(negedge clk) begin
    if (bus0.done_rx === 1'b1) begin
      rx0_cnt++;
      cap0_dout = bus0.dout_rx;
      cap0_perr = bus0.parity_err;
      cap0_ferr = bus0.frame_err;
    end
    if (bus1.done_rx === 1'b1) begin
      rx1_cnt++;
      cap1_dout = bus1.dout_rx;
      cap1_perr = bus1.parity_err;
      cap1_ferr = bus1.frame_err;
    end
    if (bus0.done_tx === 1'b1) tx0_cnt++;
  end

  // Drive a serial bit sequence (bit 0 first) onto one DUT's rx line.
  task automatic drive_line(input logic [15:0] bits, input int n, input int cpb, input bit sel);
    for (int i = 0; i < n; i++) begin
      if (sel) rx_drv1 = bits[i];
      else     rx_drv0 = bits[i];
      repeat (cpb) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    loop0 = 1'b0; loop1 = 1'b0; rx_drv0 = 1'b1; rx_drv1 = 1'b1;
    bus0.tx_valid = 1'b0; bus0.din_tx = '0;
    bus1.tx_valid = 1'b0; bus1.din_tx = '0;
    repeat (5) @(negedge clk);
    checks++; if (bus0.tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", bus0.tx); end
    checks++; if (bus0.tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b want 1", bus0.tx_ready); end
    checks++; if (bus0.done_tx !== 1'b0) begin errors++; $display("FAIL reset_done_tx: got %b want 0", bus0.done_tx); end
    checks++; if (bus0.dout_rx !== 8'h00) begin errors++; $display("FAIL reset_dout_rx: got %h want 00", bus0.dout_rx); end
    checks++; if (bus0.done_rx !== 1'b0) begin errors++; $display("FAIL reset_done_rx: got %b want 0", bus0.done_rx); end
    checks++; if ({bus0.parity_err, bus0.frame_err} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {bus0.parity_err, bus0.frame_err}); end
    checks++; if ({bus1.tx, bus1.tx_ready} !== 2'b11) begin errors++; $display("FAIL reset_dut1_tx: got %b want 11", {bus1.tx, bus1.tx_ready}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tx_a5();
    logic [9:0] pat;
    int bad_tx, bad_done;
    pat = {1'b1, 8'hA5, 1'b0};
    bad_tx = 0; bad_done = 0;
    bus0.din_tx = 8'hA5; bus0.tx_valid = 1'b1;
    @(negedge clk);
    bus0.tx_valid = 1'b0;
    checks++; if (bus0.tx_ready !== 1'b0) begin errors++; $display("FAIL tx_a5_ready_drop: got %b want 0", bus0.tx_ready); end
    for (int n = 0; n < 1040; n++) begin
      if (bus0.tx !== pat[n / 104]) bad_tx++;
      if (bus0.done_tx !== 1'b0) bad_done++;
      @(negedge clk);
    end
    checks++; if (bad_tx != 0) begin errors++; $display("FAIL tx_a5_bits: %0d cycles wrong, want 0", bad_tx); end
    checks++; if (bad_done != 0) begin errors++; $display("FAIL tx_a5_early_done: %0d cycles with done_tx, want 0", bad_done); end
    checks++; if (bus0.done_tx !== 1'b1) begin errors++; $display("FAIL tx_a5_done_at_1040: got %b want 1", bus0.done_tx); end
    checks++; if (bus0.tx_ready !== 1'b1) begin errors++; $display("FAIL tx_a5_ready_back: got %b want 1", bus0.tx_ready); end
    checks++; if (bus0.tx !== 1'b1) begin errors++; $display("FAIL tx_a5_idle_line: got %b want 1", bus0.tx); end
    @(negedge clk);
    checks++; if (bus0.done_tx !== 1'b0) begin errors++; $display("FAIL tx_a5_done_width: got %b want 0", bus0.done_tx); end
  endtask

  task automatic test_loopback();
    int sent, rcv, cyc, gaps, gap_bad, flag_bad;
    bit gap_chk;
    sent = 0; rcv = 0; cyc = 0; gaps = 0; gap_bad = 0; flag_bad = 0; gap_chk = 1'b0;
    loop0 = 1'b1;
    while (rcv < 10 && cyc < 12000) begin
      if (gap_chk) begin
        if (bus0.tx !== 1'b0) gap_bad++;
        gaps++;
        gap_chk = 1'b0;
      end
      if (bus0.done_rx === 1'b1) begin
        checks++;
        if (bus0.dout_rx !== lb_tbl[rcv]) begin
          errors++; $display("FAIL loopback_data[%0d]: got %h want %h", rcv, bus0.dout_rx, lb_tbl[rcv]);
        end
        if (bus0.parity_err !== 1'b0 || bus0.frame_err !== 1'b0) flag_bad++;
        rcv++;
      end
      if (bus0.tx_ready === 1'b1) begin
        if (sent < 10) begin
          if (sent > 0 && bus0.done_tx === 1'b1) gap_chk = 1'b1;
          bus0.din_tx = lb_tbl[sent]; bus0.tx_valid = 1'b1; sent++;
        end else begin
          bus0.tx_valid = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus0.tx_valid = 1'b0;
    checks++; if (rcv != 10) begin errors++; $display("FAIL loopback_count: got %0d frames want 10", rcv); end
    checks++; if (flag_bad != 0) begin errors++; $display("FAIL loopback_flags: %0d frames flagged want 0", flag_bad); end
    checks++; if (gaps != 9 || gap_bad != 0) begin errors++; $display("FAIL loopback_no_gap: %0d of %0d restarts late, want 0 of 9", gap_bad, gaps); end
    repeat (200) @(negedge clk);
    loop0 = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_glitch();
    int base;
    base = rx0_cnt;
    rx_drv0 = 1'b0;
    repeat (20) @(negedge clk);
    rx_drv0 = 1'b1;
    repeat (300) @(negedge clk);
    checks++; if (rx0_cnt != base) begin errors++; $display("FAIL glitch_no_done: got %0d done_rx want 0", rx0_cnt - base); end
    checks++; if (bus0.dout_rx !== 8'h96) begin errors++; $display("FAIL glitch_dout_kept: got %h want 96", bus0.dout_rx); end
    checks++; if ({bus0.parity_err, bus0.frame_err} !== 2'b00) begin errors++; $display("FAIL glitch_flags: got %b want 00", {bus0.parity_err, bus0.frame_err}); end
  endtask

  task automatic test_frame_err();
    int base;
    base = rx0_cnt;
    drive_line({1'b0, 8'h3C, 1'b0}, 10, 104, 1'b0);
    rx_drv0 = 1'b1;
    repeat (208) @(negedge clk);
    checks++; if (rx0_cnt != base + 1) begin errors++; $display("FAIL ferr_done_count: got %0d want 1", rx0_cnt - base); end
    checks++; if (cap0_dout !== 8'h3C) begin errors++; $display("FAIL ferr_dout: got %h want 3c", cap0_dout); end
    checks++; if (cap0_ferr !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b want 1", cap0_ferr); end
    checks++; if (cap0_perr !== 1'b0) begin errors++; $display("FAIL ferr_perr: got %b want 0", cap0_perr); end
    checks++; if (bus0.frame_err !== 1'b1) begin errors++; $display("FAIL ferr_held: got %b want 1", bus0.frame_err); end
    drive_line({1'b1, 8'hC3, 1'b0}, 10, 104, 1'b0);
    rx_drv0 = 1'b1;
    repeat (208) @(negedge clk);
    checks++; if (rx0_cnt != base + 2) begin errors++; $display("FAIL ferr_clean_count: got %0d want 2", rx0_cnt - base); end
    checks++; if (cap0_dout !== 8'hC3) begin errors++; $display("FAIL ferr_clean_dout: got %h want c3", cap0_dout); end
    checks++; if (cap0_ferr !== 1'b0) begin errors++; $display("FAIL ferr_cleared: got %b want 0", cap0_ferr); end
  endtask

  task automatic test_parity();
    int base, cyc;
    base = rx1_cnt;
    loop1 = 1'b1;
    bus1.din_tx = 7'h55; bus1.tx_valid = 1'b1;
    @(negedge clk);
    bus1.tx_valid = 1'b0;
    for (int n = 0; n < 176; n++) begin
      if (n == 136) begin
        checks++; if (bus1.tx !== 1'b1) begin errors++; $display("FAIL par_tx_bit: got %b want 1", bus1.tx); end
      end
      if (n == 168) begin
        checks++; if (bus1.tx !== 1'b1) begin errors++; $display("FAIL par_tx_stop2: got %b want 1", bus1.tx); end
      end
      @(negedge clk);
    end
    checks++; if (bus1.done_tx !== 1'b1) begin errors++; $display("FAIL par_done_tx_176: got %b want 1", bus1.done_tx); end
    cyc = 0;
    while (rx1_cnt == base && cyc < 100) begin @(negedge clk); cyc++; end
    checks++; if (rx1_cnt != base + 1) begin errors++; $display("FAIL par_rx_count: got %0d want 1", rx1_cnt - base); end
    checks++; if (cap1_dout !== 7'h55) begin errors++; $display("FAIL par_rx_dout: got %h want 55", cap1_dout); end
    checks++; if ({cap1_perr, cap1_ferr} !== 2'b00) begin errors++; $display("FAIL par_rx_flags: got %b want 00", {cap1_perr, cap1_ferr}); end
    loop1 = 1'b0;
    rx_drv1 = 1'b1;
    repeat (20) @(negedge clk);
    drive_line({1'b1, 1'b1, 1'b0, 7'h55, 1'b0}, 11, 16, 1'b1);
    rx_drv1 = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (rx1_cnt != base + 2) begin errors++; $display("FAIL par_bad_count: got %0d want 2", rx1_cnt - base); end
    checks++; if (cap1_perr !== 1'b1) begin errors++; $display("FAIL par_bad_flag: got %b want 1", cap1_perr); end
    checks++; if (cap1_dout !== 7'h55) begin errors++; $display("FAIL par_bad_dout: got %h want 55", cap1_dout); end
    checks++; if (cap1_ferr !== 1'b0) begin errors++; $display("FAIL par_bad_ferr: got %b want 0", cap1_ferr); end
  endtask

  task automatic test_reset_mid();
    logic [9:0] fr;
    int base_tx, base_rx, cyc;
    fr = {1'b1, 8'h5A, 1'b0};
    base_tx = tx0_cnt; base_rx = rx0_cnt;
    for (int t = 0; t < 571; t++) begin
      rx_drv0 = fr[t / 104];
      if (t == 100) begin bus0.din_tx = 8'h00; bus0.tx_valid = 1'b1; end
      if (t == 101) bus0.tx_valid = 1'b0;
      if (t == 569) begin
        checks++; if (bus0.tx !== 1'b0) begin errors++; $display("FAIL rstmid_pre_tx: got %b want 0", bus0.tx); end
      end
      if (t == 570) begin rst = 1'b1; rx_drv0 = 1'b1; end
      @(negedge clk);
    end
    checks++; if (bus0.tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx: got %b want 1", bus0.tx); end
    checks++; if (bus0.tx_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", bus0.tx_ready); end
    checks++; if (bus0.dout_rx !== 8'h00) begin errors++; $display("FAIL rstmid_dout: got %h want 00", bus0.dout_rx); end
    checks++; if ({bus0.done_tx, bus0.done_rx, bus0.parity_err, bus0.frame_err} !== 4'b0000) begin
      errors++; $display("FAIL rstmid_pulses_flags: got %b want 0000", {bus0.done_tx, bus0.done_rx, bus0.parity_err, bus0.frame_err});
    end
    rst = 1'b0;
    repeat (1500) @(negedge clk);
    checks++; if (tx0_cnt != base_tx) begin errors++; $display("FAIL rstmid_no_done_tx: got %0d want 0", tx0_cnt - base_tx); end
    checks++; if (rx0_cnt != base_rx) begin errors++; $display("FAIL rstmid_no_done_rx: got %0d want 0", rx0_cnt - base_rx); end
    loop0 = 1'b1;
    bus0.din_tx = 8'h96; bus0.tx_valid = 1'b1;
    @(negedge clk);
    bus0.tx_valid = 1'b0;
    cyc = 0;
    while ((tx0_cnt == base_tx || rx0_cnt == base_rx) && cyc < 1300) begin @(negedge clk); cyc++; end
    checks++; if (tx0_cnt != base_tx + 1) begin errors++; $display("FAIL rstmid_next_tx: got %0d want 1", tx0_cnt - base_tx); end
    checks++; if (rx0_cnt != base_rx + 1) begin errors++; $display("FAIL rstmid_next_rx: got %0d want 1", rx0_cnt - base_rx); end
    checks++; if (cap0_dout !== 8'h96) begin errors++; $display("FAIL rstmid_next_dout: got %h want 96", cap0_dout); end
    checks++; if ({cap0_perr, cap0_ferr} !== 2'b00) begin errors++; $display("FAIL rstmid_next_flags: got %b want 00", {cap0_perr, cap0_ferr}); end
    loop0 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tx_a5();
    test_loopback();
    test_glitch();
    test_frame_err();
    test_parity();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_core_param.md
Name: uart_core_param

Overview:
- Parametrised full-duplex UART transceiver; next generation of the fixed 8N1 UART_Top.
- Adds configurable data width, parity mode, stop-bit count, ready/valid TX handshake, 2-flop RX synchroniser, mid-bit RX sampling, start-glitch rejection, and parity/framing error flags.
- Sits between a host register/FIFO interface and the board serial pins.

Parameters:
- CLK_FREQ, 1000000: system clock frequency in Hz.
- BAUD, 9600: line rate in bit/s.
  - CLKS_PER_BIT = CLK_FREQ/BAUD, truncated; 104 at defaults.
  - Must be >= 4; elaboration error otherwise.
- DATA_BITS, 8: data bits per frame, legal range 5..9.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- din_tx  in  DATA_BITS  TX data; sampled at handshake.
- tx_valid  in  1  host requests transmission of din_tx.
- tx_ready  out  1  transmitter idle, can accept a frame.
- tx  out  1  serial output, idle high.
- done_tx  out  1  one-cycle pulse when a frame's last stop bit completes.
- rx  in  1  serial input; asynchronous to clk.
- dout_rx  out  DATA_BITS  last received data word.
- done_rx  out  1  one-cycle pulse when dout_rx and the error flags update.
- parity_err  out  1  parity mismatch on the last frame; held until the next done_rx.
- frame_err  out  1  a stop bit sampled low on the last frame; held until the next done_rx.

Behaviour:
- Reset values: tx=1, tx_ready=1, done_tx=0, dout_rx=0, done_rx=0, parity_err=0, frame_err=0. Both FSMs go to IDLE; all counters clear.
- Reset mid-frame: the frame is abandoned, tx=1 on the cycle after rst is sampled high, and no done pulse is generated.
- Frame format: start(0), DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits(1).
- Parity bit value: even mode sends XOR of the data bits; odd mode sends the inverse of that XOR.
- Every bit lasts exactly CLKS_PER_BIT clk cycles, counted by a per-direction divider counter.
- TX FSM:
  - States: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE.
  - tx_ready=1 only in IDLE. Handshake occurs when tx_valid && tx_ready on a clock edge: din_tx is latched and the FSM enters START.
  - tx drives 0 starting the next cycle.
  - DATA: a bit index counts 0..DATA_BITS-1; the shift register moves one bit every CLKS_PER_BIT cycles.
  - STOP: lasts STOP_BITS*CLKS_PER_BIT cycles.
  - On the first IDLE cycle after STOP: done_tx=1 for one cycle and tx_ready=1 in that same cycle.
  - Back-to-back frames: if tx_valid is held, the next start bit follows immediately, with no extra idle bit.
  - tx_valid and din_tx are ignored while tx_ready=0.
- RX path:
  - rx passes through a 2-flop synchroniser to give rx_s. All RX decisions use rx_s (2-cycle input latency).
  - States: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE.
  - IDLE: rx_s==0 enters START and clears the divider.
  - START: after CLKS_PER_BIT/2 cycles, resample. If rx_s==1 it is a glitch: return to IDLE with no done_rx and no flag change. Otherwise enter DATA.
  - DATA / PARITY / STOP: sample rx_s every CLKS_PER_BIT cycles, i.e. at bit centre. Data is shifted in LSB first.
  - Parity: the received parity bit is compared with the computed parity; a mismatch sets the pending parity error.
  - Stop bits: each stop bit is checked; any stop sample of 0 sets the pending framing error.
  - After the last stop sample, on the next cycle: dout_rx, parity_err and frame_err update, done_rx=1 for one cycle, and the FSM returns to IDLE.
  - A frame with frame_err is still delivered on dout_rx.
  - With rx held low after a framing error, a new START is entered immediately (break condition); each such frame reports frame_err.
- TX and RX are fully independent and may run simultaneously.
- All outputs are registered.

Test Plan:
- Defaults, reset held 5 cycles, then handshake din_tx=8'hA5 -> tx_ready drops the next cycle; tx shows 0,1,0,1,0,0,1,0,1,1 with each bit 104 cycles; done_tx pulses once exactly 1040 cycles after tx falls.
- Loopback (tx wired to rx), 10 random bytes with tx_valid held -> each frame yields done_rx with dout_rx equal to the sent byte; flags 0; no idle gap between frames.
- PARITY=2, DATA_BITS=7, STOP_BITS=2: send 7'h55, then inject a frame with the parity bit flipped -> first frame: parity bit 1, parity_err=0; second frame: done_rx with parity_err=1 and correct dout_rx.
- Drive rx low for 20 cycles, then high -> glitch rejected: no done_rx, flags unchanged, RX back in IDLE.
- Frame 8'h3C with the stop bit driven 0 -> done_rx, dout_rx=8'h3C, frame_err=1; the next clean frame clears frame_err.
- Assert rst during TX data bit 3 and during RX data bit 4 -> tx=1 the next cycle, tx_ready=1, no done_tx or done_rx, outputs at reset values; a following frame completes normally.
